// File: rtl/lp805x_sfrresp_if.sv
// SFR read handshake between the peripheral-side responder (slave) and the
// SFR sync controller (master).
interface lp805x_sfrresp_if #(
  parameter int DWIDTH = 8
);
  logic              sfr_prrdy;
  logic              sfr_pget;
  logic              sfr_pwrdy;
  logic              sfr_pput;
  logic [DWIDTH-1:0] sfr_pdata;

  modport master (
    input  sfr_prrdy,
    input  sfr_pwrdy,
    input  sfr_pdata,
    output sfr_pget,
    output sfr_pput
  );

  modport slave (
    output sfr_prrdy,
    output sfr_pwrdy,
    output sfr_pdata,
    input  sfr_pget,
    input  sfr_pput
  );
endinterface

// File: rtl/lp805x_sfrresp.sv
// Peripheral-side SFR read responder: buffers peripheral bytes in a FIFO and
// offers them one at a time to the sync controller, retiring each on sfr_pput.
module lp805x_sfrresp #(
  parameter int DWIDTH  = 8,
  parameter int DEPTH   = 4,
  parameter int AWIDTH  = 2,
  parameter int GET_TMO = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              flush,
  input  logic              clr_ovr,
  lp805x_sfrresp_if.slave   sfr,
  output logic              full,
  output logic              empty,
  output logic [AWIDTH:0]   count,
  output logic              overrun
);
  localparam int TWIDTH = $clog2(GET_TMO + 1);

  typedef enum logic [1:0] {IDLE, OFFER, WAIT_GET, READY} state_t;

  state_t            state;
  logic [TWIDTH-1:0] tmo;
  logic              prrdy;
  logic              pwrdy;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH-1:0] wr_ptr;
  logic              pop;
  logic              push_ok;
  logic              push_drop;

  // A pop frees the slot first, so a push alongside a pop is accepted even when full.
  assign pop       = (state == READY) && sfr.sfr_pput && !flush;
  assign push_ok   = push && !flush && (!full || pop);
  assign push_drop = push && !flush && full && !pop;

  assign full          = (count == (AWIDTH+1)'(DEPTH));
  assign empty         = (count == '0);
  assign sfr.sfr_pdata = mem[rd_ptr];
  assign sfr.sfr_prrdy = prrdy;
  assign sfr.sfr_pwrdy = pwrdy;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + AWIDTH'(1);
        end
        if (push_ok) begin
          wr_ptr <= wr_ptr + AWIDTH'(1);
        end
        if (push_ok && !pop) begin
          count <= count + (AWIDTH+1)'(1);
        end else if (pop && !push_ok) begin
          count <= count - (AWIDTH+1)'(1);
        end
      end
      if (push_drop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

  // prrdy is raised only on the transition into OFFER, so it can never last two cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tmo   <= '0;
      prrdy <= 1'b0;
      pwrdy <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      prrdy <= 1'b0;
      pwrdy <= 1'b0;
    end else begin
      prrdy <= 1'b0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state <= OFFER;
            prrdy <= 1'b1;
          end
        end
        OFFER: begin
          tmo   <= TWIDTH'(GET_TMO);
          state <= WAIT_GET;
        end
        WAIT_GET: begin
          if (sfr.sfr_pget) begin
            state <= READY;
            pwrdy <= 1'b1;
          end else begin
            tmo <= tmo - TWIDTH'(1);
            if (tmo <= TWIDTH'(1)) begin
              state <= OFFER;
              prrdy <= 1'b1;
            end
          end
        end
        READY: begin
          if (sfr.sfr_pput) begin
            state <= IDLE;
            pwrdy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          pwrdy <= 1'b0;
        end
      endcase
    end
  end
endmodule
